btb_bimodal: RTL and testbench
==============================

// Module: btb_bimodal
// PURPOSE
//  Parametrised branch target buffer with per-entry 2-bit confidence counters and on-board branch statistics.
//  Looks up the fetch PC in IF, carries the prediction down the IF->ID->EX pipe, and resolves it against the
//  EX-stage branch outcome. Drives mispredict/redirect to pc and exposes saturating hit/mispredict counters.
// PARAMETERS
//  ENTRIES    16  number of direct-mapped entries; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  PC_W       16  instruction address width (word addressed, sequential PC = PC+1)
//  CNT_W      16  width of each statistics counter
//  PRED_MODE  1   0 = predict taken on any tag hit; 1 = predict taken only if ctr[1]==1
// PORTS
//  clk                input   1      clock
//  rst_n              input   1      synchronous active-low reset
//  PC                 input   PC_W   IF-stage fetch address
//  stall_IM_ID        input   1      hold IM_ID pipe regs
//  stall_ID_EX        input   1      hold ID_EX pipe regs
//  stall_EX_DM        input   1      EX stage stalled; blocks update/stats
//  br_instr_ID_EX     input   1      branch/jump-class instruction in EX
//  flow_change_ID_EX  input   1      branch resolved taken in EX
//  dst_ID_EX          input   PC_W   resolved branch target in EX
//  stat_clr           input   1      synchronous clear of statistics counters
//  hit                output  1      IF: predict taken (comb)
//  target_PC          output  PC_W   IF: predicted target (comb)
//  btb_hit_ID_EX      output  1      prediction carried to EX
//  mispr              output  1      EX: mispredict, flush IM_ID and ID_EX (comb)
//  fix_PC             output  PC_W   EX: correct next PC when mispr=1 (comb)
//  inc_br_cnt, inc_hit_cnt, inc_mispr_cnt  output 1  one-cycle event pulses (registered)
//  br_cnt, hit_cnt, mispr_cnt              output CNT_W  saturating statistics
// BEHAVIOUR
//  Storage per entry: valid, tag = PC[PC_W-1:IDX_W], target[PC_W], ctr[1:0]; index = PC[IDX_W-1:0].
//  Lookup comb: tag_hit = valid & tag match; hit = tag_hit & (PRED_MODE==0 | ctr[1]); target_PC = entry target.
//  Pipe: {hit,target,PC} -> *_IM_ID when !stall_IM_ID; IM_ID -> *_ID_EX when !stall_ID_EX.
//  Flush: mispr=1 clears hit_IM_ID and hit_ID_EX next edge; flush beats stall.
//  Resolve event ev = br_instr_ID_EX & ~stall_EX_DM (exactly one per branch instance).
//  mispr = ev & (hit_ID_EX != flow_change_ID_EX | (hit_ID_EX & flow_change_ID_EX & tgt_ID_EX != dst_ID_EX)).
//  fix_PC = flow_change_ID_EX ? dst_ID_EX : pc_ID_EX + 1 (mod 2^PC_W).
//  Update on ev, entry at pc_ID_EX index:
//   taken & tag match: target <= dst_ID_EX, ctr <= sat_inc(ctr) (max 3).
//   taken & no match: allocate/overwrite: valid=1, new tag, target=dst_ID_EX, ctr=2'b10.
//   not taken & match: ctr <= sat_dec(ctr) (min 0), entry stays valid. not taken & no match: no change.
//  Same-cycle lookup/update same index: lookup sees pre-update contents.
//  Stats on ev: br_cnt++; mispr ? mispr_cnt++ : hit_cnt++. Counters saturate at all-ones.
//  Pulses inc_* asserted the cycle after the counted ev. stat_clr zeroes counters and beats same-cycle increment.
//  Reset: all valid=0, ctr=0, pipe regs 0, counters 0, inc_* 0. Hence hit=0, btb_hit_ID_EX=0, mispr=0.
//  fix_PC is don't-care with no ev. Reset mid-operation drops all in-flight predictions.
// TESTING
//  1 Reset, PC=0x0005 -> hit=0; branch at 0x0005 taken to 0x0040 -> mispr=1, fix_PC=0x0040, entry ctr=2.
//  2 Refetch 0x0005 -> hit=1, target_PC=0x0040; taken in EX -> mispr=0, hit_cnt+1, ctr=3; then 3 not-taken -> ctr 2,1,0; PRED_MODE=1 hit=0 at ctr<=1.
//  3 Hit predicted 0x0040, resolved taken to 0x0050 -> mispr=1, fix_PC=0x0050, target rewritten.
//  4 Predicted taken, resolved not taken at pc 0x0005 -> mispr=1, fix_PC=0x0006; IM_ID/ID_EX hits cleared.
//  5 stall_EX_DM=1 for 3 cycles with branch in EX -> br_cnt increments once only; stall_ID_EX holds hit_ID_EX.
//  6 CNT_W=4: 20 branches -> br_cnt=15 saturated; stat_clr with ev same cycle -> br_cnt=0.

Source files
------------

// File: rtl/btb_bimodal_if.sv
// Fetch/resolve bundle between the pipeline and the branch target buffer.
// The pipeline side uses master and the buffer uses slave.
interface btb_bimodal_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  PC;
    logic             stall_IM_ID;
    logic             stall_ID_EX;
    logic             stall_EX_DM;
    logic             br_instr_ID_EX;
    logic             flow_change_ID_EX;
    logic [PC_W-1:0]  dst_ID_EX;
    logic             stat_clr;
    logic             hit;
    logic [PC_W-1:0]  target_PC;
    logic             btb_hit_ID_EX;
    logic             mispr;
    logic [PC_W-1:0]  fix_PC;
    logic             inc_br_cnt;
    logic             inc_hit_cnt;
    logic             inc_mispr_cnt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] mispr_cnt;

    modport master (
        output PC, stall_IM_ID, stall_ID_EX, stall_EX_DM, br_instr_ID_EX,
               flow_change_ID_EX, dst_ID_EX, stat_clr,
        input  hit, target_PC, btb_hit_ID_EX, mispr, fix_PC,
               inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, br_cnt, hit_cnt, mispr_cnt
    );

    modport slave (
        input  PC, stall_IM_ID, stall_ID_EX, stall_EX_DM, br_instr_ID_EX,
               flow_change_ID_EX, dst_ID_EX, stat_clr,
        output hit, target_PC, btb_hit_ID_EX, mispr, fix_PC,
               inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, br_cnt, hit_cnt, mispr_cnt
    );
endinterface

// File: rtl/btb_bimodal.sv
// Direct-mapped branch target buffer with 2-bit confidence counters, prediction
// carried IF->ID->EX, EX-stage resolution and saturating branch statistics.
module btb_bimodal #(
    parameter int ENTRIES   = 16,
    parameter int PC_W      = 16,
    parameter int CNT_W     = 16,
    parameter int PRED_MODE = 1
) (
    input logic       clk,
    input logic       rst_n,
    btb_bimodal_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic             valid_r [ENTRIES];
    logic [TAG_W-1:0] tag_r   [ENTRIES];
    logic [PC_W-1:0]  tgt_r   [ENTRIES];
    logic [1:0]       ctr_r   [ENTRIES];

    logic             hit_im_id_r, hit_id_ex_r;
    logic [PC_W-1:0]  tgt_im_id_r, tgt_id_ex_r;
    logic [PC_W-1:0]  pc_im_id_r, pc_id_ex_r;
    logic [CNT_W-1:0] br_cnt_r, hit_cnt_r, mispr_cnt_r;
    logic             inc_br_r, inc_hit_r, inc_mispr_r;

    logic [IDX_W-1:0] if_idx_s, ex_idx_s;
    logic [TAG_W-1:0] if_tag_s, ex_tag_s;
    logic             if_hit_s, ex_match_s, ev_s, mispr_s;
    logic [PC_W-1:0]  fix_pc_s;

    assign if_idx_s = bus.PC[IDX_W-1:0];
    assign if_tag_s = bus.PC[PC_W-1:IDX_W];
    assign ex_idx_s = pc_id_ex_r[IDX_W-1:0];
    assign ex_tag_s = pc_id_ex_r[PC_W-1:IDX_W];

    // IF lookup, EX resolution and redirect target
    always_comb begin
        if_hit_s   = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s) &&
                     ((PRED_MODE == 32'sd0) || ctr_r[if_idx_s][1]);
        ex_match_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
        ev_s       = bus.br_instr_ID_EX && !bus.stall_EX_DM;
        mispr_s    = ev_s && ((hit_id_ex_r != bus.flow_change_ID_EX) ||
                     (hit_id_ex_r && bus.flow_change_ID_EX && (tgt_id_ex_r != bus.dst_ID_EX)));
        if (bus.flow_change_ID_EX) begin
            fix_pc_s = bus.dst_ID_EX;
        end else begin
            fix_pc_s = pc_id_ex_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Table training on each resolved branch; lookups this cycle see the old contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= {TAG_W{1'b0}};
                tgt_r[i]   <= {PC_W{1'b0}};
                ctr_r[i]   <= 2'b00;
            end
        end else if (ev_s) begin
            if (bus.flow_change_ID_EX) begin
                if (ex_match_s) begin
                    tgt_r[ex_idx_s] <= bus.dst_ID_EX;
                    ctr_r[ex_idx_s] <= ctr_inc(ctr_r[ex_idx_s]);
                end else begin
                    valid_r[ex_idx_s] <= 1'b1;
                    tag_r[ex_idx_s]   <= ex_tag_s;
                    tgt_r[ex_idx_s]   <= bus.dst_ID_EX;
                    ctr_r[ex_idx_s]   <= 2'b10;
                end
            end else if (ex_match_s) begin
                ctr_r[ex_idx_s] <= ctr_dec(ctr_r[ex_idx_s]);
            end
        end
    end

    // Prediction pipe; a mispredict kills younger predictions even under stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_im_id_r <= 1'b0;
            tgt_im_id_r <= {PC_W{1'b0}};
            pc_im_id_r  <= {PC_W{1'b0}};
            hit_id_ex_r <= 1'b0;
            tgt_id_ex_r <= {PC_W{1'b0}};
            pc_id_ex_r  <= {PC_W{1'b0}};
        end else begin
            if (mispr_s) begin
                hit_im_id_r <= 1'b0;
            end else if (!bus.stall_IM_ID) begin
                hit_im_id_r <= if_hit_s;
            end
            if (!bus.stall_IM_ID) begin
                tgt_im_id_r <= tgt_r[if_idx_s];
                pc_im_id_r  <= bus.PC;
            end
            if (mispr_s) begin
                hit_id_ex_r <= 1'b0;
            end else if (!bus.stall_ID_EX) begin
                hit_id_ex_r <= hit_im_id_r;
            end
            if (!bus.stall_ID_EX) begin
                tgt_id_ex_r <= tgt_im_id_r;
                pc_id_ex_r  <= pc_im_id_r;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || bus.stat_clr) begin
            br_cnt_r    <= {CNT_W{1'b0}};
            hit_cnt_r   <= {CNT_W{1'b0}};
            mispr_cnt_r <= {CNT_W{1'b0}};
        end else if (ev_s) begin
            br_cnt_r <= cnt_inc(br_cnt_r);
            if (mispr_s) begin
                mispr_cnt_r <= cnt_inc(mispr_cnt_r);
            end else begin
                hit_cnt_r <= cnt_inc(hit_cnt_r);
            end
        end
    end

    // Event pulses trail the counted resolution by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc_br_r    <= 1'b0;
            inc_hit_r   <= 1'b0;
            inc_mispr_r <= 1'b0;
        end else begin
            inc_br_r    <= ev_s && !bus.stat_clr;
            inc_hit_r   <= ev_s && !mispr_s && !bus.stat_clr;
            inc_mispr_r <= mispr_s && !bus.stat_clr;
        end
    end

    assign bus.hit           = if_hit_s;
    assign bus.target_PC     = tgt_r[if_idx_s];
    assign bus.btb_hit_ID_EX = hit_id_ex_r;
    assign bus.mispr         = mispr_s;
    assign bus.fix_PC        = fix_pc_s;
    assign bus.inc_br_cnt    = inc_br_r;
    assign bus.inc_hit_cnt   = inc_hit_r;
    assign bus.inc_mispr_cnt = inc_mispr_r;
    assign bus.br_cnt        = br_cnt_r;
    assign bus.hit_cnt       = hit_cnt_r;
    assign bus.mispr_cnt     = mispr_cnt_r;
endmodule

// File: tb/tb_btb_bimodal.sv
// Directed bench: stimulus pushes expected EX resolutions into a scoreboard,
// a negedge monitor pops and compares them whenever a branch resolves.
module tb_btb_bimodal;
    logic clk;
    logic rst_n;

    btb_bimodal_if #(.PC_W(16), .CNT_W(16)) b ();
    btb_bimodal_if #(.PC_W(16), .CNT_W(4))  b4 ();

    btb_bimodal #(.ENTRIES(16), .PC_W(16), .CNT_W(16), .PRED_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave));
    btb_bimodal #(.ENTRIES(16), .PC_W(16), .CNT_W(4), .PRED_MODE(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave));

    typedef struct packed {
        logic        mispr;
        logic [15:0] fix;
        logic        hitex;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the main instance
    initial begin
        exp_t e;
        logic pend = 1'b0;
        logic pm   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("inc_br_cnt",    {31'd0, b.inc_br_cnt},    32'd1);
                    check("inc_mispr_cnt", {31'd0, b.inc_mispr_cnt}, {31'd0, pm});
                    check("inc_hit_cnt",   {31'd0, b.inc_hit_cnt},   {31'd0, !pm});
                    pend = 1'b0;
                end else begin
                    check("inc_br_idle", {31'd0, b.inc_br_cnt}, 32'd0);
                end
                if (b.br_instr_ID_EX && !b.stall_EX_DM) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("mispr",         {31'd0, b.mispr},         {31'd0, e.mispr});
                        check("fix_PC",        {16'd0, b.fix_PC},        {16'd0, e.fix});
                        check("btb_hit_ID_EX", {31'd0, b.btb_hit_ID_EX}, {31'd0, e.hitex});
                        pend = 1'b1;
                        pm   = e.mispr;
                    end
                end
            end
        end
    end

    // Fetch pc, fetch filler behind it, then resolve pc in EX
    task automatic branch(input logic [15:0] pc, input logic [15:0] filler, input logic taken,
                          input logic [15:0] dst, input logic exp_hit, input logic [15:0] exp_tgt,
                          input logic exp_mispr, input logic [15:0] exp_fix, input logic stall_idex);
        exp_t e;
        step();
        b.PC = pc;
        #1;
        check("if_hit", {31'd0, b.hit}, {31'd0, exp_hit});
        if (exp_hit) check("target_PC", {16'd0, b.target_PC}, {16'd0, exp_tgt});
        step();
        b.PC = filler;
        step();
        b.PC = 16'h0100;
        b.br_instr_ID_EX = 1'b1;
        b.flow_change_ID_EX = taken;
        b.dst_ID_EX = dst;
        b.stall_ID_EX = stall_idex;
        e.mispr = exp_mispr;
        e.fix   = exp_fix;
        e.hitex = exp_hit;
        sb.push_back(e);
        step();
        b.br_instr_ID_EX = 1'b0;
        b.flow_change_ID_EX = 1'b0;
        b.stall_ID_EX = 1'b0;
        if (stall_idex) check("flush_over_stall", {31'd0, b.btb_hit_ID_EX}, 32'd0);
    endtask

    initial begin
        exp_t e;
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        b.PC = 16'h0005; b.stall_IM_ID = 1'b0; b.stall_ID_EX = 1'b0; b.stall_EX_DM = 1'b0;
        b.br_instr_ID_EX = 1'b0; b.flow_change_ID_EX = 1'b0; b.dst_ID_EX = 16'h0000; b.stat_clr = 1'b0;
        b4.PC = 16'h0000; b4.stall_IM_ID = 1'b0; b4.stall_ID_EX = 1'b0; b4.stall_EX_DM = 1'b0;
        b4.br_instr_ID_EX = 1'b0; b4.flow_change_ID_EX = 1'b0; b4.dst_ID_EX = 16'h0000; b4.stat_clr = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("rst_hit",     {31'd0, b.hit},           32'd0);
        check("rst_hitex",   {31'd0, b.btb_hit_ID_EX}, 32'd0);
        check("rst_br_cnt",  {16'd0, b.br_cnt},        32'd0);
        check("rst_inc_br",  {31'd0, b.inc_br_cnt},    32'd0);

        // allocate, train up, then train down to zero
        branch(16'h0005, 16'h0100, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0);
        branch(16'h0005, 16'h0100, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b0);
        branch(16'h0005, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0006, 1'b0);
        branch(16'h0005, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0006, 1'b0);
        branch(16'h0005, 16'h0100, 1'b0, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b0);
        b.PC = 16'h0005;
        #1;
        check("ctr0_hit", {31'd0, b.hit}, 32'd0);
        check("br_cnt_5",    {16'd0, b.br_cnt},    32'd5);
        check("hit_cnt_5",   {16'd0, b.hit_cnt},   32'd2);
        check("mispr_cnt_5", {16'd0, b.mispr_cnt}, 32'd3);

        // retrain, then wrong target rewrites the entry
        branch(16'h0005, 16'h0100, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0);
        branch(16'h0005, 16'h0100, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0);
        branch(16'h0005, 16'h0100, 1'b1, 16'h0050, 1'b1, 16'h0040, 1'b1, 16'h0050, 1'b0);

        // predicted-taken sitting in IM_ID must be flushed by the mispredict
        branch(16'h0005, 16'h0005, 1'b0, 16'h0050, 1'b1, 16'h0050, 1'b1, 16'h0006, 1'b0);
        step();
        check("im_id_flush", {31'd0, b.btb_hit_ID_EX}, 32'd0);

        // EX stall: counted once, ID_EX holds its prediction
        b.PC = 16'h0005;
        #1;
        check("stall_if_hit", {31'd0, b.hit},       32'd1);
        check("stall_if_tgt", {16'd0, b.target_PC}, 32'h0050);
        step();
        b.PC = 16'h0100;
        step();
        b.stall_IM_ID = 1'b1; b.stall_ID_EX = 1'b1; b.stall_EX_DM = 1'b1;
        b.br_instr_ID_EX = 1'b1; b.flow_change_ID_EX = 1'b1; b.dst_ID_EX = 16'h0050;
        e.mispr = 1'b0; e.fix = 16'h0050; e.hitex = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < 3; i++) begin
            check("stall_mispr",  {31'd0, b.mispr},         32'd0);
            check("stall_hitex",  {31'd0, b.btb_hit_ID_EX}, 32'd1);
            check("stall_br_cnt", {16'd0, b.br_cnt},        32'd9);
            step();
        end
        b.stall_IM_ID = 1'b0; b.stall_ID_EX = 1'b0; b.stall_EX_DM = 1'b0;
        step();
        b.br_instr_ID_EX = 1'b0; b.flow_change_ID_EX = 1'b0;
        check("stall_br_cnt_after", {16'd0, b.br_cnt}, 32'd10);

        // mispredict under stall_ID_EX still clears the carried hit
        branch(16'h0005, 16'h0100, 1'b0, 16'h0050, 1'b1, 16'h0050, 1'b1, 16'h0006, 1'b1);
        check("br_cnt_end",    {16'd0, b.br_cnt},    32'd11);
        check("hit_cnt_end",   {16'd0, b.hit_cnt},   32'd3);
        check("mispr_cnt_end", {16'd0, b.mispr_cnt}, 32'd8);

        // 4-bit counters saturate; clear beats same-cycle increment
        b4.br_instr_ID_EX = 1'b1;
        repeat (20) step();
        check("sat_br_cnt",    {28'd0, b4.br_cnt},    32'd15);
        check("sat_hit_cnt",   {28'd0, b4.hit_cnt},   32'd15);
        check("sat_mispr_cnt", {28'd0, b4.mispr_cnt}, 32'd0);
        b4.stat_clr = 1'b1;
        step();
        check("clr_br_cnt",  {28'd0, b4.br_cnt},  32'd0);
        check("clr_hit_cnt", {28'd0, b4.hit_cnt}, 32'd0);
        b4.stat_clr = 1'b0;
        step();
        b4.br_instr_ID_EX = 1'b0;
        check("post_clr_br_cnt", {28'd0, b4.br_cnt}, 32'd1);

        // reset mid-flight drops predictions and statistics
        b.PC = 16'h0005;
        step();
        b.PC = 16'h0100;
        step();
        check("inflight_hitex", {31'd0, b.btb_hit_ID_EX}, 32'd1);
        rst_n = 1'b0;
        b.PC = 16'h0005;
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rst_hitex",  {31'd0, b.btb_hit_ID_EX}, 32'd0);
        check("mid_rst_hit",    {31'd0, b.hit},           32'd0);
        check("mid_rst_br_cnt", {16'd0, b.br_cnt},        32'd0);
        step();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
